// File: rtl/ec_scalar_mul_seq_if.sv
// ----------------------------------------------------------------------------
// ec_scalar_mul_seq_if
// Groups the handshake and data signals of the elliptic-curve scalar
// multiplication sequencer. The sequencer connects to this bundle through the
// slave modport. The master modport is the view from the requester and from
// the point add/double unit.
//
// Signal groups:
//   in_*          start strobe plus operands (P, k, prime, a), driven toward the sequencer
//   ec_in_valid,  request pulse plus operands, driven toward the point unit
//   ec_P*/Q*/prime/a
//   ec_out_valid, result strobe plus coordinates, returned by the point unit
//   ec_R*
//   busy, out_*   status and final result from the sequencer
//   out_err       timeout flag; present only when EC_SEQ_TIMEOUT_EN is defined
// ----------------------------------------------------------------------------
interface ec_scalar_mul_seq_if #(
  parameter int K_WIDTH = 6,
  parameter int W       = 6
);
  logic               in_valid;
  logic [W-1:0]       in_Px;
  logic [W-1:0]       in_Py;
  logic [K_WIDTH-1:0] in_k;
  logic [W-1:0]       in_prime;
  logic [W-1:0]       in_a;

  logic               ec_in_valid;
  logic [W-1:0]       ec_Px;
  logic [W-1:0]       ec_Py;
  logic [W-1:0]       ec_Qx;
  logic [W-1:0]       ec_Qy;
  logic [W-1:0]       ec_prime;
  logic [W-1:0]       ec_a;
  logic               ec_out_valid;
  logic [W-1:0]       ec_Rx;
  logic [W-1:0]       ec_Ry;

  logic               busy;
  logic               out_valid;
  logic [W-1:0]       out_Rx;
  logic [W-1:0]       out_Ry;
  logic               out_inf;
`ifdef EC_SEQ_TIMEOUT_EN
  logic               out_err;
`endif

  modport slave (
    input  in_valid, in_Px, in_Py, in_k, in_prime, in_a,
    input  ec_out_valid, ec_Rx, ec_Ry,
    output ec_in_valid, ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a,
`ifdef EC_SEQ_TIMEOUT_EN
    output out_err,
`endif
    output busy, out_valid, out_Rx, out_Ry, out_inf
  );

  modport master (
    output in_valid, in_Px, in_Py, in_k, in_prime, in_a,
    output ec_out_valid, ec_Rx, ec_Ry,
    input  ec_in_valid, ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a,
`ifdef EC_SEQ_TIMEOUT_EN
    input  out_err,
`endif
    input  busy, out_valid, out_Rx, out_Ry, out_inf
  );
endinterface

// File: rtl/ec_scalar_mul_seq.sv
// ----------------------------------------------------------------------------
// ec_scalar_mul_seq
// Sequences elliptic-curve scalar multiplication R = k*P. It uses left-to-right
// double-and-add and scans the bits of k from the MSB down. The accumulator A
// starts at infinity. The downstream point unit cannot represent infinity or
// inverse points, so this block resolves those cases locally with equality
// compares. It sends every other step to the point unit as a request and waits
// for the result.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; aborts any operation in flight
//   bus  ec_scalar_mul_seq_if.slave, which carries the start/operand inputs,
//        the point-unit request/response signals, busy, and out_*
//
// Optional feature, macro EC_SEQ_TIMEOUT_EN: adds a WAIT watchdog. If the
// point unit does not answer within TIMEOUT_CYCLES cycles, the operation ends
// with out_inf = 1 and out_err = 1.
// ----------------------------------------------------------------------------
module ec_scalar_mul_seq #(
  parameter int K_WIDTH        = 6,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  ec_scalar_mul_seq_if.slave     bus
);

  localparam int W     = 6;
  localparam int IDX_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(K_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};

  // Reject parameter values that make no sense at elaboration time.
  if (K_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ec_scalar_mul_seq: K_WIDTH and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DBL  = 3'd1,
    S_ADD  = 3'd2,
    S_WAIT = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       px_q, px_d, py_q, py_d;
  logic [W-1:0]       prime_q, prime_d, coef_a_q, coef_a_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [W-1:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic               acc_inf_q, acc_inf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               from_add_q, from_add_d;   // the pending request came from an ADD step
  logic               ec_in_valid_q, ec_in_valid_d;
  logic [W-1:0]       ec_px_q, ec_px_d, ec_py_q, ec_py_d;
  logic [W-1:0]       ec_qx_q, ec_qx_d, ec_qy_q, ec_qy_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d, out_inf_q, out_inf_d;
  logic [W-1:0]       out_rx_q, out_rx_d, out_ry_q, out_ry_d;
  logic               step_done_s;   // the current step finished this cycle
  logic               step_add_s;    // the finished step was an ADD
  logic               err_s;
`ifdef EC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               out_err_q;
`endif

  // Next-state and datapath logic for the double-and-add sequencer.
  always_comb begin
    state_d       = state_q;
    px_d          = px_q;
    py_d          = py_q;
    prime_d       = prime_q;
    coef_a_d      = coef_a_q;
    k_d           = k_q;
    acc_x_d       = acc_x_q;
    acc_y_d       = acc_y_q;
    acc_inf_d     = acc_inf_q;
    idx_d         = idx_q;
    from_add_d    = from_add_q;
    ec_in_valid_d = 1'b0;
    ec_px_d       = ec_px_q;
    ec_py_d       = ec_py_q;
    ec_qx_d       = ec_qx_q;
    ec_qy_d       = ec_qy_q;
    step_done_s   = 1'b0;
    step_add_s    = 1'b0;
    err_s         = 1'b0;
`ifdef EC_SEQ_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          px_d      = bus.in_Px;
          py_d      = bus.in_Py;
          k_d       = bus.in_k;
          prime_d   = bus.in_prime;
          coef_a_d  = bus.in_a;
          acc_x_d   = ZERO_W;
          acc_y_d   = ZERO_W;
          acc_inf_d = 1'b1;
          idx_d     = IDX_TOP;
          state_d   = S_DBL;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_DBL: begin
        if (acc_inf_q) begin
          step_done_s = 1'b1;
        end else if (acc_y_q == ZERO_W) begin
          // Doubling a point with y = 0 gives infinity.
          acc_inf_d   = 1'b1;
          step_done_s = 1'b1;
        end else begin
          ec_in_valid_d = 1'b1;
          ec_px_d       = acc_x_q;
          ec_py_d       = acc_y_q;
          ec_qx_d       = acc_x_q;
          ec_qy_d       = acc_y_q;
          from_add_d    = 1'b0;
`ifdef EC_SEQ_TIMEOUT_EN
          wait_cnt_d    = {CNT_W{1'b0}};
`endif
          state_d       = S_WAIT;
        end
      end

      S_ADD: begin
        step_add_s = 1'b1;
        if (acc_inf_q) begin
          acc_x_d     = px_q;
          acc_y_d     = py_q;
          acc_inf_d   = 1'b0;
          step_done_s = 1'b1;
        end else if (acc_x_q == px_q && acc_y_q != py_q) begin
          // A == -P.
          acc_inf_d   = 1'b1;
          step_done_s = 1'b1;
        end else if (acc_x_q == px_q && py_q == ZERO_W) begin
          // A == P and this point is its own inverse.
          acc_inf_d   = 1'b1;
          step_done_s = 1'b1;
        end else begin
          // A == P also goes out as a pair; the point unit detects the doubling.
          ec_in_valid_d = 1'b1;
          ec_px_d       = acc_x_q;
          ec_py_d       = acc_y_q;
          ec_qx_d       = px_q;
          ec_qy_d       = py_q;
          from_add_d    = 1'b1;
`ifdef EC_SEQ_TIMEOUT_EN
          wait_cnt_d    = {CNT_W{1'b0}};
`endif
          state_d       = S_WAIT;
        end
      end

      S_WAIT: begin
        step_add_s = from_add_q;
        if (bus.ec_out_valid) begin
          acc_x_d     = bus.ec_Rx;
          acc_y_d     = bus.ec_Ry;
          acc_inf_d   = 1'b0;
          step_done_s = 1'b1;
        end else begin
`ifdef EC_SEQ_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            acc_inf_d = 1'b1;
            err_s     = 1'b1;
            state_d   = S_OUT;
          end else begin
            state_d   = S_WAIT;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end

      S_OUT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared routing once a DBL or ADD step finishes, locally or through the point unit.
    if (step_done_s) begin
      if (!step_add_s && k_q[idx_q]) begin
        state_d = S_ADD;
      end else if (idx_q != IDX_ZERO) begin
        idx_d   = idx_q - IDX_W'(1);
        state_d = S_DBL;
      end else begin
        state_d = S_OUT;
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // Registered status and result outputs, derived from the next-state values.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
    out_inf_d   = 1'b0;
    out_rx_d    = ZERO_W;
    out_ry_d    = ZERO_W;
    if (state_d == S_OUT) begin
      out_inf_d = acc_inf_d;
      out_rx_d  = acc_inf_d ? ZERO_W : acc_x_d;
      out_ry_d  = acc_inf_d ? ZERO_W : acc_y_d;
    end else begin
      out_inf_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      px_q          <= ZERO_W;
      py_q          <= ZERO_W;
      prime_q       <= ZERO_W;
      coef_a_q      <= ZERO_W;
      k_q           <= {K_WIDTH{1'b0}};
      acc_x_q       <= ZERO_W;
      acc_y_q       <= ZERO_W;
      acc_inf_q     <= 1'b1;
      idx_q         <= IDX_ZERO;
      from_add_q    <= 1'b0;
      ec_in_valid_q <= 1'b0;
      ec_px_q       <= ZERO_W;
      ec_py_q       <= ZERO_W;
      ec_qx_q       <= ZERO_W;
      ec_qy_q       <= ZERO_W;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_inf_q     <= 1'b0;
      out_rx_q      <= ZERO_W;
      out_ry_q      <= ZERO_W;
`ifdef EC_SEQ_TIMEOUT_EN
      wait_cnt_q    <= {CNT_W{1'b0}};
      out_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      px_q          <= px_d;
      py_q          <= py_d;
      prime_q       <= prime_d;
      coef_a_q      <= coef_a_d;
      k_q           <= k_d;
      acc_x_q       <= acc_x_d;
      acc_y_q       <= acc_y_d;
      acc_inf_q     <= acc_inf_d;
      idx_q         <= idx_d;
      from_add_q    <= from_add_d;
      ec_in_valid_q <= ec_in_valid_d;
      ec_px_q       <= ec_px_d;
      ec_py_q       <= ec_py_d;
      ec_qx_q       <= ec_qx_d;
      ec_qy_q       <= ec_qy_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_inf_q     <= out_inf_d;
      out_rx_q      <= out_rx_d;
      out_ry_q      <= out_ry_d;
`ifdef EC_SEQ_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      out_err_q     <= err_s;
`endif
    end
  end

  assign bus.ec_in_valid = ec_in_valid_q;
  assign bus.ec_Px       = ec_px_q;
  assign bus.ec_Py       = ec_py_q;
  assign bus.ec_Qx       = ec_qx_q;
  assign bus.ec_Qy       = ec_qy_q;
  assign bus.ec_prime    = prime_q;
  assign bus.ec_a        = coef_a_q;
  assign bus.busy        = busy_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_Rx      = out_rx_q;
  assign bus.out_Ry      = out_ry_q;
  assign bus.out_inf     = out_inf_q;
`ifdef EC_SEQ_TIMEOUT_EN
  assign bus.out_err     = out_err_q;
`endif

endmodule

// File: tb/tb_ec_scalar_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_ec_scalar_mul_seq
// Directed bench for ec_scalar_mul_seq on the curve y^2 = x^3 + 2x + 2 over
// GF(17) with P = (5,1), a group of order 19. A point-unit model computes real
// affine add/double results after 3 cycles. Expected results are pushed to a
// scoreboard when each operation starts. A monitor collects the results the
// DUT produces, and each pair is compared with immediate assertions.
// ----------------------------------------------------------------------------
module tb_ec_scalar_mul_seq;
  localparam int KW = 6;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ec_scalar_mul_seq_if #(.K_WIDTH(KW)) seq_bus ();

  ec_scalar_mul_seq #(.K_WIDTH(KW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (seq_bus)
  );

  typedef struct { int x; int y; int inf; int err; int calls; } res_t;
  res_t exp_q[$];
  res_t obs_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int calls_cnt = 0;
  logic [35:0] last_ops = '0;
  logic model_en = 1'b1;
  logic inject   = 1'b0;
  int pend = 0, cnt = 0, mx = 0, my = 0;

  function automatic int modinv(input int v, input int p);
    for (int i = 1; i < p; i++) if ((v * i) % p == 1) return i;
    return 0;
  endfunction

  // Affine add/double over GF(p); equal operands mean doubling.
  function automatic logic [11:0] pt_op(input int x1, input int y1, input int x2,
                                        input int y2, input int p, input int a);
    int num, den, lam, x3, y3;
    if (x1 == x2 && y1 == y2) begin
      num = (3 * x1 * x1 + a) % p;
      den = (2 * y1) % p;
    end else begin
      num = ((y2 - y1) % p + p) % p;
      den = ((x2 - x1) % p + p) % p;
    end
    lam = (num * modinv(den, p)) % p;
    x3  = ((lam * lam - x1 - x2) % p + p) % p;
    y3  = ((lam * (x1 - x3) - y1) % p + p) % p;
    return {x3[5:0], y3[5:0]};
  endfunction

  // Point-unit model: 3-cycle latency, plus an optional injected spurious strobe.
  always @(negedge clk) begin
    logic [11:0] r;
    seq_bus.ec_out_valid = 1'b0;
    if (pend != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        pend = 0;
        seq_bus.ec_out_valid = 1'b1;
        seq_bus.ec_Rx = mx[5:0];
        seq_bus.ec_Ry = my[5:0];
      end
    end
    if (inject) begin
      seq_bus.ec_out_valid = 1'b1;
      seq_bus.ec_Rx = 6'd7;
      seq_bus.ec_Ry = 6'd7;
    end
    if (seq_bus.ec_in_valid === 1'b1 && model_en) begin
      r = pt_op(seq_bus.ec_Px, seq_bus.ec_Py, seq_bus.ec_Qx, seq_bus.ec_Qy,
                seq_bus.ec_prime, seq_bus.ec_a);
      mx = r[11:6];
      my = r[5:0];
      pend = 1;
      cnt = 3;
    end
  end

  // Monitor: count point-unit requests per operation and record each result.
  always @(negedge clk) begin
    res_t o;
    if (rst) begin
      calls_cnt = 0;
    end else begin
      if (seq_bus.ec_in_valid === 1'b1) begin
        calls_cnt = calls_cnt + 1;
        last_ops = {seq_bus.ec_Px, seq_bus.ec_Py, seq_bus.ec_Qx, seq_bus.ec_Qy,
                    seq_bus.ec_prime, seq_bus.ec_a};
      end
      if (seq_bus.out_valid === 1'b1) begin
        o.x = seq_bus.out_Rx;
        o.y = seq_bus.out_Ry;
        o.inf = seq_bus.out_inf;
`ifdef EC_SEQ_TIMEOUT_EN
        o.err = seq_bus.out_err;
`else
        o.err = 0;
`endif
        o.calls = calls_cnt;
        obs_q.push_back(o);
        calls_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int x, input int y, input int inf, input int err, input int calls);
    res_t e;
    e.x = x; e.y = y; e.inf = inf; e.err = err; e.calls = calls;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [5:0] k);
    @(posedge clk); #1;
    seq_bus.in_valid = 1'b1;
    seq_bus.in_k = k;
    seq_bus.in_Px = 6'd5;
    seq_bus.in_Py = 6'd1;
    seq_bus.in_prime = 6'd17;
    seq_bus.in_a = 6'd2;
    @(posedge clk); #1;
    seq_bus.in_valid = 1'b0;
    seq_bus.in_Px = 6'h3F;
    seq_bus.in_Py = 6'h2A;
    seq_bus.in_k = 6'h15;
  endtask

  task automatic collect(input string tag);
    res_t e, o;
    int t = 0;
    while (obs_q.size() == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_result_seen"}, obs_q.size() > 0, 1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_Rx"}, o.x, e.x);
      chk({tag, "_Ry"}, o.y, e.y);
      chk({tag, "_inf"}, o.inf, e.inf);
      chk({tag, "_calls"}, o.calls, e.calls);
`ifdef EC_SEQ_TIMEOUT_EN
      chk({tag, "_err"}, o.err, e.err);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t;
    rst = 1'b1;
    seq_bus.in_valid = 1'b0;
    seq_bus.in_k = '0;
    seq_bus.in_Px = '0;
    seq_bus.in_Py = '0;
    seq_bus.in_prime = '0;
    seq_bus.in_a = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", seq_bus.out_valid, 0);
    chk("rst_busy", seq_bus.busy, 0);
    chk("rst_ec_in_valid", seq_bus.ec_in_valid, 0);
    chk("rst_out_inf", seq_bus.out_inf, 0);
    chk("rst_out_Rx", seq_bus.out_Rx, 0);
    chk("rst_ec_Px", seq_bus.ec_Px, 0);
    chk("rst_ec_prime", seq_bus.ec_prime, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // k=1: all steps local, so out_valid arrives in cycle 8.
    push_exp(5, 1, 0, 0, 0);
    start(6'd1);
    chk("k1_busy", seq_bus.busy, 1);
    lat = 1;
    while (seq_bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("k1_latency", lat, 8);
    collect("k1");
    @(negedge clk);
    chk("k1_busy_after", seq_bus.busy, 0);

    // k=2: one doubling call with operands (5,1,5,1).
    push_exp(6, 3, 0, 0, 1);
    start(6'd2);
    collect("k2");
    chk("k2_ops", last_ops, {6'd5, 6'd1, 6'd5, 6'd1, 6'd17, 6'd2});

    // k=5 while a second in_valid with other operands arrives mid-operation.
    push_exp(9, 16, 0, 0, 3);
    start(6'd5);
    repeat (3) @(posedge clk);
    #1;
    seq_bus.in_valid = 1'b1;
    seq_bus.in_k = 6'd1;
    seq_bus.in_Px = 6'd3;
    seq_bus.in_Py = 6'd4;
    seq_bus.in_prime = 6'd13;
    seq_bus.in_a = 6'd0;
    @(posedge clk); #1;
    seq_bus.in_valid = 1'b0;
    collect("k5_busy_ignore");
    chk("k5_ops_prime_a", last_ops[11:0], {6'd17, 6'd2});

    push_exp(5, 16, 0, 0, 5);
    start(6'd18);
    collect("k18");

    // k=19: the final ADD sees A = -P and resolves locally to infinity.
    push_exp(0, 0, 1, 0, 5);
    start(6'd19);
    collect("k19");

    push_exp(0, 0, 1, 0, 0);
    start(6'd0);
    collect("k0");

    push_exp(16, 13, 0, 0, 10);
    start(6'd63);
    collect("k63");

    // Spurious point-unit strobe while idle.
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    repeat (5) @(negedge clk);
    chk("spur_no_out", obs_q.size(), 0);
    chk("spur_busy", seq_bus.busy, 0);
    push_exp(6, 3, 0, 0, 1);
    start(6'd2);
    collect("k2_after_spur");

    // Reset while waiting on the point unit; the late strobe must be ignored.
    start(6'd2);
    t = 0;
    while (seq_bus.ec_in_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rstwait_issue_seen", seq_bus.ec_in_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstwait_out_valid", seq_bus.out_valid, 0);
    chk("rstwait_busy", seq_bus.busy, 0);
    chk("rstwait_ec_in_valid", seq_bus.ec_in_valid, 0);
    chk("rstwait_ec_Px", seq_bus.ec_Px, 0);
    chk("rstwait_out_inf", seq_bus.out_inf, 0);
    repeat (10) @(negedge clk);
    chk("rstwait_no_out", obs_q.size(), 0);
    chk("rstwait_idle", seq_bus.busy, 0);
    push_exp(9, 16, 0, 0, 3);
    start(6'd5);
    collect("k5_after_rst");

`ifdef EC_SEQ_TIMEOUT_EN
    // The point unit never answers, so the watchdog fires TO cycles into WAIT.
    model_en = 1'b0;
    push_exp(0, 0, 1, 1, 1);
    start(6'd2);
    t = 0;
    while (seq_bus.ec_in_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    lat = 0;
    while (seq_bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("timeout_cycles", lat, TO);
    collect("timeout");
    @(negedge clk);
    chk("timeout_err_clear", seq_bus.out_err, 0);
    model_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size() + obs_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
